// File: rtl/ysyx_25040129_lsu.sv
// Memory-access stage: one instruction in flight, issues a single request/response
// bus transaction for loads and stores, and hands the extended result to WBU.
`ifndef REGS_DIG
`define REGS_DIG 5
`endif
`ifndef CSR_DIG
`define CSR_DIG 12
`endif

module ysyx_25040129_lsu (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 is_req_valid_from_exu,
    output logic                 is_req_ready_to_exu,
    input  logic [31:0]          result_in_lsu,
    input  logic [31:0]          lsu_write_data_in_lsu,
    input  logic [2:0]           lsu_read_in_lsu,
    input  logic [1:0]           lsu_write_in_lsu,
    input  logic [`REGS_DIG-1:0] rd_in_lsu,
    input  logic                 reg_write_in_lsu,
    input  logic                 csr_write_in_lsu,
    input  logic [`CSR_DIG-1:0]  csr_write_addr_in_lsu,
    input  logic                 ecall_in_lsu,
    input  logic                 mret_in_lsu,
    input  logic                 fence_i_in_lsu,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [31:0]          mem_addr,
    output logic                 mem_wen,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_wstrb,
    input  logic                 mem_resp_valid,
    input  logic [31:0]          mem_rdata,
    output logic                 mem_resp_ready,
    output logic                 is_req_valid_to_wbu,
    input  logic                 is_req_ready_from_wbu,
    output logic [31:0]          result_out_lsu,
    output logic [`REGS_DIG-1:0] rd_out_lsu,
    output logic                 reg_write_out_lsu,
    output logic                 csr_write_out_lsu,
    output logic [`CSR_DIG-1:0]  csr_write_addr_out_lsu,
    output logic                 ecall_out_lsu,
    output logic                 mret_out_lsu,
    output logic                 fence_i_out_lsu
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state;
    logic [2:0]  load_q;
    logic [1:0]  off_q;
    logic        accept;
    logic        is_store;
    logic        is_load;
    logic [1:0]  off_in;
    logic [3:0]  strb_next;
    logic [31:0] wdata_next;
    logic [31:0] raw;
    logic [31:0] load_ext;

    assign is_req_ready_to_exu = (state == S_IDLE) && !rst;
    assign accept   = is_req_valid_from_exu && is_req_ready_to_exu;
    // A store takes precedence; load codes 6 and 7 behave like "no load".
    assign is_store = (lsu_write_in_lsu != 2'd0);
    assign is_load  = !is_store && (lsu_read_in_lsu >= 3'd1) && (lsu_read_in_lsu <= 3'd5);
    assign off_in   = result_in_lsu[1:0];

    always_comb begin
        strb_next  = 4'b0000;
        wdata_next = 32'd0;
        case (lsu_write_in_lsu)
            2'd1:    strb_next = 4'b0001 << off_in;
            2'd2:    strb_next = 4'b0011 << off_in;
            2'd3:    strb_next = 4'b1111;
            default: strb_next = 4'b0000;
        endcase
        if (is_store)
            wdata_next = lsu_write_data_in_lsu << {off_in, 3'b000};
    end

    always_comb begin
        raw      = mem_rdata >> {off_q, 3'b000};
        load_ext = raw;
        case (load_q)
            3'd1:    load_ext = {{24{raw[7]}}, raw[7:0]};
            3'd2:    load_ext = {{16{raw[15]}}, raw[15:0]};
            3'd4:    load_ext = {24'd0, raw[7:0]};
            3'd5:    load_ext = {16'd0, raw[15:0]};
            default: load_ext = raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= S_IDLE;
            load_q                 <= 3'd0;
            off_q                  <= 2'd0;
            mem_req_valid          <= 1'b0;
            mem_addr               <= 32'd0;
            mem_wen                <= 1'b0;
            mem_wdata              <= 32'd0;
            mem_wstrb              <= 4'd0;
            mem_resp_ready         <= 1'b0;
            is_req_valid_to_wbu    <= 1'b0;
            result_out_lsu         <= 32'd0;
            rd_out_lsu             <= '0;
            reg_write_out_lsu      <= 1'b0;
            csr_write_out_lsu      <= 1'b0;
            csr_write_addr_out_lsu <= '0;
            ecall_out_lsu          <= 1'b0;
            mret_out_lsu           <= 1'b0;
            fence_i_out_lsu        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        load_q                 <= is_load ? lsu_read_in_lsu : 3'd0;
                        off_q                  <= off_in;
                        mem_addr               <= {result_in_lsu[31:2], 2'b00};
                        mem_wen                <= is_store;
                        mem_wdata              <= wdata_next;
                        mem_wstrb              <= strb_next;
                        result_out_lsu         <= result_in_lsu;
                        rd_out_lsu             <= rd_in_lsu;
                        reg_write_out_lsu      <= reg_write_in_lsu;
                        csr_write_out_lsu      <= csr_write_in_lsu;
                        csr_write_addr_out_lsu <= csr_write_addr_in_lsu;
                        ecall_out_lsu          <= ecall_in_lsu;
                        mret_out_lsu           <= mret_in_lsu;
                        fence_i_out_lsu        <= fence_i_in_lsu;
                        if (is_store || is_load) begin
                            state         <= S_REQ;
                            mem_req_valid <= 1'b1;
                        end else begin
                            state               <= S_DONE;
                            is_req_valid_to_wbu <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        state          <= S_WAIT;
                        mem_req_valid  <= 1'b0;
                        mem_resp_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        if (load_q != 3'd0)
                            result_out_lsu <= load_ext;
                        state               <= S_DONE;
                        mem_resp_ready      <= 1'b0;
                        is_req_valid_to_wbu <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (is_req_ready_from_wbu) begin
                        state               <= S_IDLE;
                        is_req_valid_to_wbu <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/ysyx_25040129_lsu.md
# ysyx_25040129_lsu

Memory-access stage of the ysyx_25040129 pipeline, directly downstream of the execute stage. It accepts one instruction at a time from EXU over a valid/ready handshake and performs the byte/half/word load or store on a simple request/response memory bus. It sign- or zero-extends load data and forwards the writeback result plus control fields to WBU over a second valid/ready handshake. Instructions with no memory operation pass through with one cycle of registered latency.

## Interface
Parameters:
- none. Widths come from the global macros `REGS_DIG` and `CSR_DIG`.

Ports:
- clk  in  1  Single clock, rising-edge.
- rst  in  1  Reset, synchronous and active-high.
- is_req_valid_from_exu  in  1  EXU holds a valid instruction.
- is_req_ready_to_exu  out  1  Stage can accept an instruction.
- result_in_lsu  in  32  ALU result; this is the effective address for loads and stores.
- lsu_write_data_in_lsu  in  32  Store data (rs2).
- lsu_read_in_lsu  in  3  Load type: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; 6 and 7 are treated as none.
- lsu_write_in_lsu  in  2  Store type: 0 none, 1 SB, 2 SH, 3 SW.
- rd_in_lsu, reg_write_in_lsu, csr_write_in_lsu, csr_write_addr_in_lsu, ecall_in_lsu, mret_in_lsu, fence_i_in_lsu  in  `REGS_DIG`/1/1/`CSR_DIG`/1/1/1  Control fields, latched on accept.
- mem_req_valid  out  1  Memory request pending.
- mem_req_ready  in  1  Memory accepts the request.
- mem_addr  out  32  Word-aligned address: {addr[31:2],2'b00}.
- mem_wen  out  1  1 = store, 0 = load.
- mem_wdata  out  32  Store data, lane-shifted.
- mem_wstrb  out  4  Byte strobes; 0 for loads.
- mem_resp_valid  in  1  Response (read data or write ack) available.
- mem_rdata  in  32  Read data.
- mem_resp_ready  out  1  Stage consumes the response.
- is_req_valid_to_wbu  out  1  Result valid for WBU.
- is_req_ready_from_wbu  in  1  WBU accepts the result.
- result_out_lsu  out  32  Extended load data for loads; the latched ALU result otherwise.
- rd_out_lsu, reg_write_out_lsu, csr_write_out_lsu, csr_write_addr_out_lsu, ecall_out_lsu, mret_out_lsu, fence_i_out_lsu  out  Registered copies of the corresponding inputs.

## Operation
State machine: IDLE, REQ, WAIT, DONE.
- IDLE
  - is_req_ready_to_exu=1 (forced to 0 while rst=1).
  - On valid&&ready: latch all inputs.
  - If a load or store is present, go to REQ; otherwise go to DONE.
- REQ
  - mem_req_valid=1; mem_addr, mem_wen, mem_wdata and mem_wstrb are held stable.
  - On mem_req_ready, go to WAIT.
- WAIT
  - mem_resp_ready=1.
  - On mem_resp_valid: for loads, latch the extended rdata into result_out_lsu. Go to DONE.
- DONE
  - is_req_valid_to_wbu=1; all *_out_lsu outputs are held stable.
  - On is_req_ready_from_wbu, go to IDLE.
- Byte offset off=addr[1:0].
  - Stores: wdata = data << (8*off).
  - Strobes: SB 4'b0001<<off, SH 4'b0011<<off, SW 4'b1111. Strobes are truncated to 4 bits.
- Loads: raw = mem_rdata >> (8*off).
  - LB: sign-extend raw[7:0]. LBU: zero-extend raw[7:0].
  - LH: sign-extend raw[15:0]. LHU: zero-extend raw[15:0].
  - LW: raw.
- Misaligned accesses are not trapped. The shift/strobe rule above is applied as-is.
- If a load and a store are both nonzero, the store wins and the load is ignored.
- A response arriving outside WAIT is ignored. mem_resp_ready=0 outside WAIT.

## Timing
- Reset (synchronous): state=IDLE.
  - All outputs are 0 during and after reset, except is_req_ready_to_exu, which is 1 in the first cycle after rst deasserts.
  - Reset mid-transaction abandons the instruction with no WBU output. mem_req_valid drops at the reset edge.
- Non-memory instruction: accepted at edge N; is_req_valid_to_wbu=1 in cycle N+1. Best-case throughput is one instruction per 2 cycles.
- Memory instruction with mem_req_ready=1 immediately and mem_resp_valid one cycle later:
  - accept at N
  - mem_req_valid in N+1
  - WAIT in N+2 with response
  - valid_to_wbu in N+3
- Request and response may not complete in the same cycle. Response is sampled only in WAIT.
- is_req_ready_to_exu is 0 in REQ, WAIT and DONE. There is no accept overlapping DONE.
- Backpressure: DONE is held indefinitely while is_req_ready_from_wbu=0.

## Test plan
- Reset, then ALU op with result 0x1234_5678, rd=5, reg_write=1 -> valid_to_wbu one cycle after accept; result 0x1234_5678; rd=5.
- SB addr 0x8000_0003, data 0xAABB_CCDD -> mem_addr 0x8000_0000, wstrb 4'b1000, wdata 0xDD00_0000, wen=1.
- LB addr 0x8000_0001, rdata 0x0000_8000 -> result 0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
- LH addr 0x8000_0002, rdata 0x8765_0000 -> result 0xFFFF_8765. SH at same address, data 0x1234 -> wstrb 4'b1100.
- mem_req_ready held 0 for 5 cycles, then 1; response delayed 3 cycles; WBU ready held 0 for 2 cycles -> outputs stable throughout; exactly one WBU transfer; is_req_ready_to_exu=0 until return to IDLE.
- rst asserted while in WAIT -> IDLE next edge; all outputs 0; a stray mem_resp_valid is ignored; no WBU valid.
